reg_arb: RTL

REG_ARB -- requirements
Module: reg_arb

---
 rtl/reg_arb_pkg.sv | 27 ++
 rtl/reg_arb_rr.sv | 20 ++
 rtl/reg_arb.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/reg_arb_pkg.sv
// Purpose: shared operation and FSM state encodings for the reg_arb register arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package reg_arb_pkg;

   // Operation a requester asks to perform on the shared register
   typedef enum logic [1:0] {
      OP_LOAD   = 2'b00,
      OP_CLEAR  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

   // Transaction sequencer states; every non-idle state lasts exactly one cycle
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_APPLY = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   // Requester index to one-hot requester vector
   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/reg_arb_rr.sv
// Purpose: two-requester round-robin winner select (combinational).
// Latency: zero cycles; winner follows req/pointer in the same cycle.
// Backpressure: none; pointer only matters when both requesters contend.
module reg_arb_rr
   import reg_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       pointer,
   output logic [1:0] winner
);

   // A lone request always wins; on contention the pointer picks the requester
   always_comb begin
      winner = req;
      if (req == 2'b11) begin
         winner = idx_to_onehot(pointer);
      end
   end

endmodule

// File: rtl/reg_arb.sv
// Purpose: arbitrates two requesters onto one shared WIDTH-bit register (LOAD/CLEAR/SET/TOGGLE); optional REG_ARB_LOCK_EN adds a lock input that keeps priority on the last winner.
// Latency: req seen in IDLE at cycle 0 -> gnt cycle 1 -> q updated and done pulse cycle 3 -> IDLE cycle 4.
// Backpressure: requests arriving while busy are held off until the next IDLE cycle; dropping req during GRANT aborts with no side effects.
module reg_arb
   import reg_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic [1:0]       req,
   input  logic [1:0]       op0,
   input  logic [1:0]       op1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
`ifdef REG_ARB_LOCK_EN
   input  logic [1:0]       lock,
`endif
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic [WIDTH-1:0] q,
   output logic             busy
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic             r_ptr;
   logic             r_win;
   op_e              r_op;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_q;

   logic [1:0]       w_win_oh;
   logic             w_win_idx;
   logic             w_arb;
   logic             w_cap;
   logic             w_apply;
   logic             w_ptr_upd;
   logic             w_ptr_nxt;
   logic [WIDTH-1:0] w_q_nxt;

   reg_arb_rr u_rr (
      .req     (req),
      .pointer (r_ptr),
      .winner  (w_win_oh)
   );

   assign w_win_idx = (w_win_oh == 2'b10);
   assign q         = r_q;

`ifdef REG_ARB_LOCK_EN
   // A locked winner keeps the pointer so it also wins the next contention
   assign w_ptr_nxt = lock[r_win] ? r_win : ~r_win;
`else
   assign w_ptr_nxt = ~r_win;
`endif

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and per-state outputs
   always_comb begin
      w_state_nxt = r_state;
      gnt         = 2'b00;
      done        = 2'b00;
      busy        = 1'b1;
      w_arb       = 1'b0;
      w_cap       = 1'b0;
      w_apply     = 1'b0;
      w_ptr_upd   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (req != 2'b00) begin
               w_arb       = 1'b1;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            gnt = idx_to_onehot(r_win);
            if (req[r_win]) begin
               w_cap       = 1'b1;
               w_state_nxt = ST_APPLY;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_APPLY: begin
            w_apply     = 1'b1;
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done        = idx_to_onehot(r_win);
            w_ptr_upd   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Latch the arbitration winner when leaving IDLE
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_win <= 1'b0;
      end else if (w_arb) begin
         r_win <= w_win_idx;
      end
   end

   // Capture only the winner's op/data at the edge leaving GRANT
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_op   <= OP_LOAD;
         r_data <= '0;
      end else if (w_cap) begin
         r_op   <= r_win ? op_e'(op1) : op_e'(op0);
         r_data <= r_win ? data1 : data0;
      end
   end

   // New register value computed from the captured operation
   always_comb begin
      w_q_nxt = r_q;
      case (r_op)
         OP_LOAD:   w_q_nxt = r_data;
         OP_CLEAR:  w_q_nxt = '0;
         OP_SET:    w_q_nxt = '1;
         OP_TOGGLE: w_q_nxt = r_q ^ r_data;
         default:   w_q_nxt = r_q;
      endcase
   end

   // Shared register, written only at the edge leaving APPLY
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_q <= '0;
      end else if (w_apply) begin
         r_q <= w_q_nxt;
      end
   end

   // Round-robin pointer advances once per completed transaction
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_ptr <= 1'b0;
      end else if (w_ptr_upd) begin
         r_ptr <= w_ptr_nxt;
      end
   end

endmodule
